// File: rtl/cell_scan_ctrl.sv
// cell_scan_ctrl: row-major sequencer building 3x3 occupancy windows
// for the CellState classifier and writing results to the tile map.
module cell_scan_ctrl #(
  parameter  int W  = 16,
  parameter  int H  = 12,
  localparam int AW = $clog2(W*H)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          map_rd_en,
  output logic [AW-1:0] map_rd_addr,
  input  logic          map_rd_data,
  output logic [8:0]    cs_in,
  input  logic [3:0]    cs_out,
  output logic          tile_wr_en,
  output logic [AW-1:0] tile_wr_addr,
  output logic [3:0]    tile_wr_data
);

  localparam int XW = $clog2(W);
  localparam int YW = $clog2(H);

  typedef enum logic [2:0] {
    IDLE, READ, CAP, WRITE, DONE
  } state_t;

  state_t        state, state_nx;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [3:0]    k, idx;
  logic          rd_q;
  logic [8:0]    win, win_nx, cs_q;
  logic [1:0]    kx, ky;
  logic [XW:0]   nx;
  logic [YW:0]   ny;
  logic          inb, last;
  logic [AW-1:0] naddr, caddr;

  // Negative neighbour coords wrap to large values, so one compare
  // per axis covers both grid edges.
  always_comb begin
    ky = 2'd0;
    if (k >= 4'd6)
      ky = 2'd2;
    else if (k >= 4'd3)
      ky = 2'd1;
    kx = 2'(k - 4'(ky) * 4'd3);
    nx = (XW+1)'(x) + (XW+1)'(kx) - (XW+1)'(1);
    ny = (YW+1)'(y) + (YW+1)'(ky) - (YW+1)'(1);
    inb = (nx < (XW+1)'(W)) && (ny < (YW+1)'(H));
    naddr = AW'(ny) * AW'(W) + AW'(nx);
    caddr = AW'(y) * AW'(W) + AW'(x);
    last = (x == XW'(W-1)) && (y == YW'(H-1));
    win_nx = win;
    if (rd_q)
      win_nx[idx] = map_rd_data;
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    busy         = 1'b0;
    done         = 1'b0;
    map_rd_en    = 1'b0;
    map_rd_addr  = '0;
    tile_wr_en   = 1'b0;
    tile_wr_addr = '0;
    tile_wr_data = 4'h0;
    unique case (state)
      IDLE: begin
        if (start)
          state_nx = READ;
      end
      READ: begin
        busy        = 1'b1;
        map_rd_en   = inb;
        map_rd_addr = inb ? naddr : '0;
        if (k == 4'd8)
          state_nx = CAP;
      end
      CAP: begin
        busy     = 1'b1;
        state_nx = WRITE;
      end
      WRITE: begin
        busy         = 1'b1;
        tile_wr_en   = 1'b1;
        tile_wr_addr = caddr;
        tile_wr_data = cs_out;
        state_nx     = last ? DONE : READ;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Read data lands one cycle late, so the slot of the previous
  // read is captured while the next neighbour is being addressed.
  always_ff @(posedge clk) begin
    if (reset) begin
      x    <= '0;
      y    <= '0;
      k    <= '0;
      idx  <= '0;
      rd_q <= 1'b0;
      win  <= '0;
      cs_q <= '0;
    end else begin
      rd_q <= map_rd_en;
      idx  <= k;
      win  <= win_nx;
      unique case (state)
        IDLE: begin
          if (start) begin
            x   <= '0;
            y   <= '0;
            k   <= '0;
            win <= '0;
          end
        end
        READ: k <= (k == 4'd8) ? 4'd0 : k + 4'd1;
        CAP: cs_q <= win_nx;
        WRITE: begin
          win <= '0;
          if (last) begin
            x <= '0;
            y <= '0;
          end else if (x == XW'(W-1)) begin
            x <= '0;
            y <= y + YW'(1);
          end else begin
            x <= x + XW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign cs_in = cs_q;

endmodule

// File: tb/tb_cell_scan_ctrl.sv
// tb_cell_scan_ctrl: directed scans over hand-built occupancy maps,
// with a reference window/read-count scoreboard per tile write.
module tb_cell_scan_ctrl;

  localparam int W  = 16;
  localparam int H  = 12;
  localparam int N  = W*H;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset, start;
  logic          busy, done;
  logic          map_rd_en, map_rd_data;
  logic [AW-1:0] map_rd_addr, tile_wr_addr;
  logic [8:0]    cs_in;
  logic [3:0]    cs_out, tile_wr_data;
  logic          tile_wr_en;

  always #5 clk = ~clk;

  logic       mem [N];
  logic [8:0] w_cs [N];
  logic [3:0] w_data [N];
  int         rd_per [N];

  int n_chk = 0;
  int n_err = 0;
  int rel, wr_idx, done_cnt, busy_cnt, rd_cnt, done_rel;
  int pulse_at, rst_at;

  // Stand-in classifier with the reference points from the tile table
  function automatic logic [3:0] cs_model(input logic [8:0] w);
    logic [3:0] r;
    case (w)
      9'h008:  r = 4'b1001;
      9'h020:  r = 4'b0001;
      9'h001:  r = 4'b0110;
      default: r = w[4] ? 4'h0 :
        {w[8]^w[0], w[6]^w[2], w[7]^w[1], w[5]^w[3]};
    endcase
    return r;
  endfunction

  assign cs_out = cs_model(cs_in);

  always @(posedge clk)
    map_rd_data <= !map_rd_en ? 1'b1 :
      (32'(map_rd_addr) < N) ? mem[map_rd_addr] : 1'b0;

  cell_scan_ctrl #(.W(W), .H(H)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .map_rd_en    (map_rd_en),
    .map_rd_addr  (map_rd_addr),
    .map_rd_data  (map_rd_data),
    .cs_in        (cs_in),
    .cs_out       (cs_out),
    .tile_wr_en   (tile_wr_en),
    .tile_wr_addr (tile_wr_addr),
    .tile_wr_data (tile_wr_data)
  );

  function automatic logic [8:0] exp_win(input int n);
    logic [8:0] w;
    int x, y, nx, ny;
    w = '0;
    x = n % W;
    y = n / W;
    for (int k = 0; k < 9; k++) begin
      nx = x + k % 3 - 1;
      ny = y + k / 3 - 1;
      if (nx >= 0 && nx < W && ny >= 0 && ny < H)
        w[k] = mem[ny*W + nx];
    end
    return w;
  endfunction

  function automatic int exp_reads(input int n);
    int x, y, nx, ny, c;
    c = 0;
    x = n % W;
    y = n / W;
    for (int k = 0; k < 9; k++) begin
      nx = x + k % 3 - 1;
      ny = y + k / 3 - 1;
      if (nx >= 0 && nx < W && ny >= 0 && ny < H)
        c++;
    end
    return c;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    logic [8:0] ew;
    @(negedge clk);
    rel++;
    start = (rel == pulse_at);
    reset = (rst_at >= 0) && (rel >= rst_at) && (rel < rst_at + 5);
    if (busy)
      busy_cnt++;
    if (map_rd_en)
      rd_cnt++;
    if (tile_wr_en) begin
      ew = exp_win(wr_idx);
      chk("wr_addr", 32'(tile_wr_addr), 32'(wr_idx));
      chk("wr_cs_in", 32'(cs_in), 32'(ew));
      chk("wr_data", 32'(tile_wr_data), 32'(cs_model(ew)));
      chk("wr_cycle", 32'(rel), 32'(11 + 11*wr_idx));
      chk("wr_reads", 32'(rd_cnt), 32'(exp_reads(wr_idx)));
      if (32'(tile_wr_addr) < N) begin
        w_cs[tile_wr_addr]   = cs_in;
        w_data[tile_wr_addr] = tile_wr_data;
        rd_per[tile_wr_addr] = rd_cnt;
      end
      rd_cnt = 0;
      wr_idx++;
    end
    if (done) begin
      done_cnt++;
      done_rel = rel;
    end
  endtask

  task automatic run(input int pulse, input int rst, input int lim);
    @(negedge clk);
    pulse_at = pulse;
    rst_at   = rst;
    rel      = 0;
    wr_idx   = 0;
    done_cnt = 0;
    busy_cnt = 0;
    rd_cnt   = 0;
    done_rel = -1;
    for (int i = 0; i < N; i++) begin
      w_cs[i]   = '1;
      w_data[i] = '1;
      rd_per[i] = -1;
    end
    start = 1'b1;
    while (rel < lim)
      tick();
    start = 1'b0;
    reset = 1'b0;
  endtask

  task automatic set_map(input int a, input logic fill);
    for (int i = 0; i < N; i++)
      mem[i] = fill;
    if (a >= 0)
      mem[a] = 1'b1;
  endtask

  task automatic full_checks(input string tag);
    chk({tag, "_writes"}, 32'(wr_idx), 32'(N));
    chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    chk({tag, "_done_cyc"}, 32'(done_rel), 32'd2113);
    chk({tag, "_busy_cyc"}, 32'(busy_cnt), 32'd2112);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    pulse_at = -1;
    rst_at   = -1;
    rel      = 0;
    set_map(-1, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rd_en", 32'(map_rd_en), 32'd0);
    chk("rst_rd_addr", 32'(map_rd_addr), 32'd0);
    chk("rst_wr_en", 32'(tile_wr_en), 32'd0);
    chk("rst_wr_addr", 32'(tile_wr_addr), 32'd0);
    chk("rst_cs_in", 32'(cs_in), 32'd0);
    reset = 1'b0;

    set_map(-1, 1'b0);
    run(-1, -1, 2125);
    full_checks("empty");
    chk("empty_d0", 32'(w_data[0]), 32'd0);
    chk("empty_d191", 32'(w_data[191]), 32'd0);

    set_map(85, 1'b0);
    run(-1, -1, 2125);
    full_checks("c55");
    chk("c55_d85", 32'(w_data[85]), 32'd0);
    chk("c55_cs86", 32'(w_cs[86]), 32'h008);
    chk("c55_d86", 32'(w_data[86]), 32'b1001);
    chk("c55_cs84", 32'(w_cs[84]), 32'h020);
    chk("c55_d84", 32'(w_data[84]), 32'b0001);

    set_map(0, 1'b0);
    run(-1, -1, 2125);
    full_checks("c00");
    chk("c00_rd0", 32'(rd_per[0]), 32'd4);
    chk("c00_cs17", 32'(w_cs[17]), 32'h001);
    chk("c00_d17", 32'(w_data[17]), 32'b0110);

    set_map(85, 1'b0);
    run(500, -1, 2125);
    full_checks("restart");

    run(-1, 560, 600);
    chk("rst_mid_writes", 32'(wr_idx), 32'd50);
    chk("rst_mid_busy", 32'(busy_cnt), 32'd560);
    chk("rst_mid_done", 32'(done_cnt), 32'd0);
    chk("rst_mid_idle", 32'(busy), 32'd0);

    set_map(-1, 1'b1);
    run(-1, -1, 2125);
    full_checks("ones");
    chk("ones_rd0", 32'(rd_per[0]), 32'd4);
    chk("ones_rd1", 32'(rd_per[1]), 32'd6);
    chk("ones_rd16", 32'(rd_per[16]), 32'd6);
    chk("ones_rd17", 32'(rd_per[17]), 32'd9);
    chk("ones_rd191", 32'(rd_per[191]), 32'd4);
    chk("ones_d17", 32'(w_data[17]), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
